// File: rtl/chacha_pkg.sv
// Shared definitions for the small-scale ChaCha link: constant, S-box, FSM states
// and a reference keystream-word function.
package chacha_pkg;

  localparam logic [3:0] CHACHA_CONST = 4'hB;

  // Entry i lives in bits [4i+3:4i]: S = 0,A,D,7,E,4,3,9,5,F,8,2,B,1,6,C
  localparam logic [63:0] SBOX_TABLE = 64'hC61B_28F5_934E_7DA0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GEN    = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_TABLE[{x, 2'b00} +: 4];
  endfunction

  // r[i][b] is bit b of box i counted MSB-first, so it maps to vector bit 3-b.
  function automatic logic [15:0] ks_word(input logic [7:0] k, input logic [1:0] n,
                                          input logic [1:0] c, input logic [3:0] cst);
    logic [3:0]  r [4];
    logic [3:0]  sel;
    logic [3:0]  cn;
    logic [15:0] w;
    cn  = {c, n};
    w   = '0;
    sel = '0;
    for (int i = 0; i < 4; i++) begin
      r[i] = sbox({cst[3-i], k[7-2*i], k[6-2*i], cn[3-i]});
    end
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) begin
        sel[3-i] = r[i][3-((i+j)%4)];
      end
      w[15-4*j -: 4] = sbox(sel);
    end
    return w;
  endfunction

endpackage

// File: rtl/chacha_ks_word.sv
// Combinational keystream word: two rounds of four S-box lookups over key, nonce
// and block counter. Shared with the encrypter side.
module chacha_ks_word
  import chacha_pkg::*;
#(
  parameter logic [3:0] CONST = CHACHA_CONST
) (
  input  logic [7:0]  i_key,
  input  logic [1:0]  i_nonce,
  input  logic [1:0]  i_ctr,
  output logic [15:0] o_word
);

  logic [3:0] w_cn;
  logic [3:0] w_r1  [4];
  logic [3:0] w_sel [4];

  assign w_cn = {i_ctr, i_nonce};

  for (genvar gi = 0; gi < 4; gi++) begin : g_round1
    assign w_r1[gi] = sbox({CONST[3-gi], i_key[7-2*gi], i_key[6-2*gi], w_cn[3-gi]});
  end

  // Output j takes bit (i+j)%4 of box i, box 0 supplying the MSB.
  for (genvar gj = 0; gj < 4; gj++) begin : g_round2
    for (genvar gi = 0; gi < 4; gi++) begin : g_tap
      assign w_sel[gj][3-gi] = w_r1[gi][3-((gi+gj)%4)];
    end
    assign o_word[15-4*gj -: 4] = sbox(w_sel[gj]);
  end

endmodule

// File: rtl/chacha_decrypter.sv
// Serial ChaCha-lite receiver: ciphertext bits in, plaintext nibbles out, NUM_BLOCKS
// blocks per start. Define CHACHA_DEC_PROTO_ERR_EN to add the sticky err output.
module chacha_decrypter
  import chacha_pkg::*;
#(
  parameter int         NUM_BLOCKS = 4,
  parameter logic [3:0] CONST      = CHACHA_CONST
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] key,
  input  logic [1:0] nonce,
  input  logic [1:0] init_ctr,
  input  logic       ct_valid,
  input  logic       ct_bit,
  output logic       ct_ready,
  output logic       pt_valid,
  output logic [3:0] pt_nibble,
  input  logic       pt_ready,
  output logic       busy,
  output logic       done
`ifdef CHACHA_DEC_PROTO_ERR_EN
  ,
  output logic       err
`endif
);

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_key;
  logic [1:0]  r_nonce;
  logic [1:0]  r_ctr;
  logic [7:0]  r_blk_left;
  logic [15:0] r_ks;
  logic [3:0]  r_bit_idx;
  logic [2:0]  r_shift;
  logic [3:0]  r_pt_nibble;
  logic        r_pt_valid;
  logic        r_done;

  logic [15:0] w_ks_word;
  logic        w_ct_ready;
  logic        w_launch;
  logic        w_gen;
  logic        w_finish;
  logic        w_accept;
  logic        w_pt_bit;
  logic        w_nibble_end;
  logic        w_block_end;

  chacha_ks_word #(.CONST(CONST)) u_ks_word (
    .i_key   (r_key),
    .i_nonce (r_nonce),
    .i_ctr   (r_ctr),
    .o_word  (w_ks_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_ct_ready   = 1'b0;
    w_launch     = 1'b0;
    w_gen        = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_launch     = 1'b1;
          w_state_next = GEN;
        end
      end
      GEN: begin
        w_gen        = 1'b1;
        w_state_next = STREAM;
      end
      STREAM: begin
        // Stall input while a finished nibble is still waiting downstream.
        w_ct_ready = !(r_pt_valid && !pt_ready);
        if (w_ct_ready && ct_valid && (r_bit_idx == 4'd0)) begin
          w_state_next = (r_blk_left == 8'd1) ? DONE : GEN;
        end
      end
      DONE: begin
        if (!r_pt_valid || pt_ready) begin
          w_finish     = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_accept     = w_ct_ready && ct_valid;
  assign w_pt_bit     = ct_bit ^ r_ks[r_bit_idx];
  assign w_nibble_end = w_accept && (r_bit_idx[1:0] == 2'd0);
  assign w_block_end  = w_accept && (r_bit_idx == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key       <= '0;
      r_nonce     <= '0;
      r_ctr       <= '0;
      r_blk_left  <= '0;
      r_ks        <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_pt_nibble <= '0;
      r_pt_valid  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_launch) begin
        r_key      <= key;
        r_nonce    <= nonce;
        r_ctr      <= init_ctr;
        r_blk_left <= 8'(NUM_BLOCKS);
      end
      if (w_gen) begin
        r_ks      <= w_ks_word;
        r_bit_idx <= 4'd15;
      end
      if (w_accept) begin
        r_shift   <= {r_shift[1:0], w_pt_bit};
        r_bit_idx <= r_bit_idx - 4'd1;
      end
      if (w_block_end) begin
        r_ctr      <= r_ctr + 2'd1;
        r_blk_left <= r_blk_left - 8'd1;
      end
      // A new nibble wins over the handshake that retires the previous one.
      if (w_nibble_end) begin
        r_pt_nibble <= {r_shift, w_pt_bit};
        r_pt_valid  <= 1'b1;
      end else if (pt_ready) begin
        r_pt_valid <= 1'b0;
      end
    end
  end

  assign ct_ready  = w_ct_ready;
  assign pt_valid  = r_pt_valid;
  assign pt_nibble = r_pt_nibble;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;

`ifdef CHACHA_DEC_PROTO_ERR_EN
  logic r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if ((ct_valid && ((r_state == IDLE) || (r_state == DONE))) ||
                 (start && (r_state != IDLE))) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_chacha_decrypter.sv
// Directed bench for chacha_decrypter (NUM_BLOCKS=2) with hand-computed keystream nibbles.
module tb_chacha_decrypter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] key = '0;
  logic [1:0] nonce = '0;
  logic [1:0] init_ctr = '0;
  logic       ct_valid = 1'b0;
  logic       ct_bit = 1'b0;
  logic       ct_ready;
  logic       pt_valid;
  logic [3:0] pt_nibble;
  logic       pt_ready = 1'b1;
  logic       busy;
  logic       done;
`ifdef CHACHA_DEC_PROTO_ERR_EN
  logic       err;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  chacha_decrypter #(.NUM_BLOCKS(2), .CONST(4'hB)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .key       (key),
    .nonce     (nonce),
    .init_ctr  (init_ctr),
    .ct_valid  (ct_valid),
    .ct_bit    (ct_bit),
    .ct_ready  (ct_ready),
    .pt_valid  (pt_valid),
    .pt_nibble (pt_nibble),
    .pt_ready  (pt_ready),
    .busy      (busy),
    .done      (done)
`ifdef CHACHA_DEC_PROTO_ERR_EN
    ,
    .err       (err)
`endif
  );

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one two-block message, feeding ct MSB-first and checking each taken nibble.
  task automatic run_msg(input logic [7:0] k, input logic [1:0] n, input logic [1:0] c,
                         input logic [31:0] ct, input logic [31:0] exp_pt,
                         input int stall_len, input string tag);
    int   bit_n;
    int   nib_n;
    int   cyc;
    int   stall_left;
    int   gap;
    int   done_n;
    logic held;
    bit_n = 0; nib_n = 0; cyc = 0; stall_left = stall_len; gap = 0; done_n = 0;
    @(negedge clk);
    key = k; nonce = n; init_ctr = c; start = 1'b1; ct_valid = 1'b0; pt_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (done_n == 0 && cyc < 200) begin
      ct_valid = (bit_n < 32);
      ct_bit   = (bit_n < 32) ? ct[31-bit_n] : 1'b0;
      held     = (stall_left > 0) && pt_valid && (nib_n == 0);
      pt_ready = !held;
      #1;
      if (held) begin
        check(32'(pt_nibble), 32'(exp_pt[31:28]), {tag, " stall_nibble"});
        check(32'(ct_ready), 32'd0, {tag, " stall_ct_ready"});
        check(32'(pt_valid), 32'd1, {tag, " stall_pt_valid"});
        stall_left--;
      end
      if (!held && !ct_ready && bit_n > 0 && bit_n < 32) gap++;
      if (pt_valid && pt_ready) begin
        if (nib_n < 8) check(32'(pt_nibble), 32'(exp_pt[31-4*nib_n -: 4]),
                             $sformatf("%s nibble%0d", tag, nib_n));
        else check(32'(nib_n), 32'd7, {tag, " extra_nibble"});
        nib_n++;
      end
      if (done) begin
        check(32'(nib_n), 32'd8, {tag, " done_after_last"});
        done_n++;
      end
      if (ct_valid && ct_ready) bit_n++;
      cyc++;
      @(negedge clk);
    end
    ct_valid = 1'b0;
    pt_ready = 1'b1;
    check(32'(done_n), 32'd1, {tag, " done_seen"});
    check(32'(bit_n), 32'd32, {tag, " bits_taken"});
    check(32'(gap), 32'd1, {tag, " gen_bubbles"});
    #1;
    check(32'(busy), 32'd0, {tag, " idle_busy"});
    check(32'(done), 32'd0, {tag, " done_one_cycle"});
    $display("msg %s: key=%h nonce=%h ctr=%h ct=%h nibbles=%0d bits=%0d cycles=%0d",
             tag, k, n, c, ct, nib_n, bit_n, cyc);
  endtask

  initial begin
    int acc;
    int cyc;
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check(32'(busy), 32'd0, "rst_busy");
    check(32'(pt_valid), 32'd0, "rst_pt_valid");
    check(32'(pt_nibble), 32'd0, "rst_pt_nibble");
    check(32'(ct_ready), 32'd0, "rst_ct_ready");
    check(32'(done), 32'd0, "rst_done");
`ifdef CHACHA_DEC_PROTO_ERR_EN
    check(32'(err), 32'd0, "rst_err");
`endif
    @(negedge clk);
    reset = 1'b0;

    // ks(0,0,0)=A8A8, ks(0,0,1)=A6A6
    run_msg(8'h00, 2'd0, 2'd0, 32'h0000_0000, 32'hA8A8_A6A6, 0, "basic");
    // ks(0,0,3)=F6F6, then counter wraps to 0
    run_msg(8'h00, 2'd0, 2'd3, 32'h0000_0000, 32'hF6F6_A8A8, 0, "wrap");
    // 0x1234 ^ 0xA8A8 = 0xBA9C
    run_msg(8'h00, 2'd0, 2'd0, 32'hBA9C_0000, 32'h1234_A6A6, 0, "roundtrip");
    run_msg(8'h00, 2'd0, 2'd0, 32'h0000_0000, 32'hA8A8_A6A6, 5, "backpressure");

    // Abort after 7 accepted bits
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; ct_valid = 1'b1; ct_bit = 1'b0; pt_ready = 1'b1;
    acc = 0; cyc = 0;
    while (acc < 7 && cyc < 50) begin
      #1;
      if (ct_ready) acc++;
      cyc++;
      @(negedge clk);
    end
    check(32'(acc), 32'd7, "abort_bits_fed");
    ct_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check(32'(busy), 32'd0, "abort_busy");
    check(32'(pt_valid), 32'd0, "abort_pt_valid");
    check(32'(ct_ready), 32'd0, "abort_ct_ready");
    check(32'(pt_nibble), 32'd0, "abort_pt_nibble");
    $display("abort: reset after %0d bits, busy=%0b pt_valid=%0b", acc, busy, pt_valid);
    @(negedge clk);
    reset = 1'b0;

    // ks(FF,3,0)=01CD, ks(FF,3,1)=0FC3; also confirms nothing survived the abort
    run_msg(8'hFF, 2'd3, 2'd0, 32'h0000_0000, 32'h01CD_0FC3, 0, "recover");

    // ct_valid in IDLE: ignored, nothing consumed
    @(negedge clk);
    ct_valid = 1'b1; ct_bit = 1'b1;
    repeat (3) begin
      #1;
      check(32'(ct_ready), 32'd0, "idle_ct_ready");
      check(32'(busy), 32'd0, "idle_busy");
      @(negedge clk);
    end
    ct_valid = 1'b0;
    $display("idle ct_valid: 3 cycles driven, ignored");
`ifdef CHACHA_DEC_PROTO_ERR_EN
    #1;
    check(32'(err), 32'd1, "err_set");
`endif
    run_msg(8'h00, 2'd0, 2'd0, 32'hBA9C_0000, 32'h1234_A6A6, 0, "after_idle_valid");
`ifdef CHACHA_DEC_PROTO_ERR_EN
    check(32'(err), 32'd1, "err_sticky");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check(32'(err), 32'd0, "err_cleared");
    @(negedge clk);
    reset = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chacha_decrypter.md
Name: chacha_decrypter

Overview:
- Receive end of the small-scale ChaCha20 link: serial ciphertext bits in, 4-bit plaintext nibbles out.
- Regenerates the 16-bit keystream word per block from latched key, nonce and running 2-bit block counter.
- XORs each keystream word MSB-first against incoming bits.
- Runs a fixed-length message of NUM_BLOCKS blocks per start, with valid/ready on both sides.

Parameters:
- NUM_BLOCKS, 4, blocks per message (1..255); each block is 16 ciphertext bits.
- CONST, 4'hB, 4-bit ChaCha constant fed to the keystream function.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse; captures key/nonce/init_ctr; honoured only in IDLE.
- key  in  8  key.
- nonce  in  2  nonce.
- init_ctr  in  2  block counter value for the first block.
- ct_valid  in  1  ciphertext bit valid.
- ct_bit  in  1  ciphertext bit.
- ct_ready  out  1  block accepts ct_bit this cycle.
- pt_valid  out  1  pt_nibble valid.
- pt_nibble  out  4  plaintext nibble; first-received bit in [3].
- pt_ready  in  1  downstream accepts nibble.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at message end.

Behaviour:
- Reset: state IDLE; all outputs 0; counter, bit index, shift register and latched key/nonce cleared.
- Reset mid-operation aborts the message; any pending nibble is discarded.
- Keystream word ks(k,n,c) uses S-box S[0..15] = 0,A,D,7,E,4,3,9,5,F,8,2,B,1,6,C. Input {A,B,C,D} is MSB-first; output {a,b,c,d} is MSB-first.
- Round 1 inputs:
  - box1 = {CONST[3],k[7],k[6],c[1]}
  - box2 = {CONST[2],k[5],k[4],c[0]}
  - box3 = {CONST[1],k[3],k[2],n[1]}
  - box4 = {CONST[0],k[1],k[0],n[0]}
  - Store ri[0]=a, ri[1]=b, ri[2]=c, ri[3]=d.
- Round 2 outputs, each taken MSB-first:
  - f1 = S{r1[0],r2[1],r3[2],r4[3]}
  - f2 = S{r1[1],r2[2],r3[3],r4[0]}
  - f3 = S{r1[2],r2[3],r3[0],r4[1]}
  - f4 = S{r1[3],r2[0],r3[1],r4[2]}
  - Word = {f1,f2,f3,f4}.
- FSM:
  - IDLE: ct_ready=0. On start, latch key/nonce, set ctr=init_ctr and blk_left=NUM_BLOCKS, go to GEN.
  - GEN (1 cycle, ct_ready=0): ks_reg<=ks(key_q,nonce_q,ctr); bit_idx<=15; go to STREAM.
  - STREAM: ct_ready = !(pt_valid && !pt_ready). On each accepted bit, shift ct_bit^ks_reg[bit_idx] into the nibble shift register and decrement bit_idx.
  - STREAM, 4th bit of a nibble accepted: pt_nibble/pt_valid register next cycle (latency 1).
  - STREAM, bit_idx==0 accepted: ctr<=ctr+1 (2-bit wrap, 3 to 0); blk_left--; go to DONE if blk_left was 1, else GEN.
  - DONE: wait until pt_valid==0 or pt_ready; pulse done for 1 cycle; go to IDLE.
- pt_valid stays high with a stable nibble until pt_ready. It clears on the handshake unless a new nibble loads in the same cycle.
- start outside IDLE is ignored. ct_valid outside STREAM is ignored; no bit is consumed.
- Throughput: 16 bits per 17 cycles at best (one GEN bubble per block).

Optional Feature:
- Macro CHACHA_DEC_PROTO_ERR_EN.
- Defined: extra output err (1 bit), sticky. Sets when ct_valid is high in IDLE or DONE, or start is high while busy. Cleared only by reset.
- Undefined: port err absent; those conditions silently ignored as above.

Decomposition:
- Package chacha_pkg:
  - CONST default.
  - 16-entry S-box constant and S-box function.
  - State enum (IDLE, GEN, STREAM, DONE).
  - Keystream-word function.
- Sub-module chacha_ks_word: combinational key/nonce/ctr to 16-bit word, 8 S-box lookups. Reused later by the encrypter rewrite.

Test Plan:
- Keystream, block 1: key=0, nonce=0, init_ctr=0, NUM_BLOCKS=1, 16 zero bits with ct_valid always high. Expect nibbles A,8,A,8 (ks=0xA8A8), then a done pulse.
- Counter advance: NUM_BLOCKS=2, same inputs, 32 zero bits. Expect A,8,A,8 then A,6,A,6 (ctr=1, ks=0xA6A6); exactly one GEN bubble (ct_ready=0 for 1 cycle) between blocks.
- Counter wrap: init_ctr=3, NUM_BLOCKS=2, key=0, nonce=0, zero ciphertext. Expect the second block equal to 0xA8A8 (ctr wrapped to 0).
- Backpressure: hold pt_ready=0 after the first nibble. Expect pt_nibble stable at A and ct_ready=0 until pt_ready rises; no bits lost; done only after the final nibble is taken.
- Round trip: ciphertext = 0x1234 XOR 0xA8A8 = 0xBA9C, fed MSB-first. Expect nibbles 1,2,3,4.
- Reset and protocol: assert reset after 7 accepted bits. Expect IDLE, pt_valid=0, busy=0 next edge. With CHACHA_DEC_PROTO_ERR_EN, ct_valid=1 in IDLE sets err=1, which stays set until reset.
